// File: rtl/vigna_bus_pkg.sv
// Shared definitions for the vigna memory bus: arbiter state encoding,
// port-select codes, strobe constants and the grant decision.
package vigna_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   typedef enum logic {
      SEL_I = 1'b0,
      SEL_D = 1'b1
   } port_sel_t;

   localparam logic [3:0] STRB_NONE = 4'b0000;
   localparam logic [3:0] STRB_WORD = 4'b1111;

   // Pick a port when at least one is requesting. On contention with
   // round-robin enabled, the port that was not served last wins; with
   // round-robin disabled the data port always wins.
   function automatic port_sel_t arb_pick(input logic i_valid,
                                          input logic d_valid,
                                          input logic last_d,
                                          input bit   rr);
      port_sel_t sel;
      sel = SEL_D;
      if (i_valid && !d_valid) begin
         sel = SEL_I;
      end else if (i_valid && d_valid && rr && last_d) begin
         sel = SEL_I;
      end
      return sel;
   endfunction

endpackage

// File: rtl/vigna_mem_arbiter.sv
// Two-master to one-slave memory arbiter below the vigna core. Merges the
// instruction-fetch and load/store ports onto one serialised memory bus with
// registered request and response paths and a one-cycle ready pulse per
// completed transaction.
module vigna_mem_arbiter
   import vigna_bus_pkg::*;
#(
   parameter bit RR = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        i_valid,
   output logic        i_ready,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,

   input  logic        d_valid,
   output logic        d_ready,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic [31:0] d_rdata,

   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic [31:0] m_rdata
);

   arb_state_t  state_reg,   state_next;
   logic        last_d_reg,  last_d_next;
   logic        m_valid_reg, m_valid_next;
   logic [31:0] m_addr_reg,  m_addr_next;
   logic [31:0] m_wdata_reg, m_wdata_next;
   logic [3:0]  m_wstrb_reg, m_wstrb_next;
   logic        i_ready_reg, i_ready_next;
   logic        d_ready_reg, d_ready_next;
   logic [31:0] i_rdata_reg, i_rdata_next;
   logic [31:0] d_rdata_reg, d_rdata_next;

   logic        do_grant;
   port_sel_t   grant_sel;

   // State and output registers; reset clears everything at once so an
   // abandoned slave transaction is dropped immediately.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg   <= IDLE;
         last_d_reg  <= 1'b0;
         m_valid_reg <= 1'b0;
         m_addr_reg  <= 32'd0;
         m_wdata_reg <= 32'd0;
         m_wstrb_reg <= STRB_NONE;
         i_ready_reg <= 1'b0;
         d_ready_reg <= 1'b0;
         i_rdata_reg <= 32'd0;
         d_rdata_reg <= 32'd0;
      end else begin
         state_reg   <= state_next;
         last_d_reg  <= last_d_next;
         m_valid_reg <= m_valid_next;
         m_addr_reg  <= m_addr_next;
         m_wdata_reg <= m_wdata_next;
         m_wstrb_reg <= m_wstrb_next;
         i_ready_reg <= i_ready_next;
         d_ready_reg <= d_ready_next;
         i_rdata_reg <= i_rdata_next;
         d_rdata_reg <= d_rdata_next;
      end
   end

   // Next-state and next-output logic: arbitrate in IDLE, wait for the slave
   // in BUSY, pulse ready and optionally cross-grant the other port in RESP.
   always_comb begin
      state_next   = state_reg;
      last_d_next  = last_d_reg;
      m_valid_next = m_valid_reg;
      m_addr_next  = m_addr_reg;
      m_wdata_next = m_wdata_reg;
      m_wstrb_next = m_wstrb_reg;
      i_ready_next = 1'b0;
      d_ready_next = 1'b0;
      i_rdata_next = i_rdata_reg;
      d_rdata_next = d_rdata_reg;
      do_grant     = 1'b0;
      grant_sel    = SEL_D;

      case (state_reg)
         IDLE: begin
            if (i_valid || d_valid) begin
               do_grant  = 1'b1;
               grant_sel = arb_pick(i_valid, d_valid, last_d_reg, RR);
            end
         end
         BUSY_I: begin
            if (m_ready) begin
               m_valid_next = 1'b0;
               m_wstrb_next = STRB_NONE;
               i_rdata_next = m_rdata;
               i_ready_next = 1'b1;
               state_next   = RESP;
            end
         end
         BUSY_D: begin
            if (m_ready) begin
               m_valid_next = 1'b0;
               m_wstrb_next = STRB_NONE;
               d_rdata_next = m_rdata;
               d_ready_next = 1'b1;
               state_next   = RESP;
            end
         end
         RESP: begin
            // The port just served still holds valid this cycle, so only the
            // other port is looked at here.
            state_next = IDLE;
            if (last_d_reg && i_valid) begin
               do_grant  = 1'b1;
               grant_sel = SEL_I;
            end else if (!last_d_reg && d_valid) begin
               do_grant  = 1'b1;
               grant_sel = SEL_D;
            end
         end
         default: state_next = IDLE;
      endcase

      if (do_grant) begin
         m_valid_next = 1'b1;
         if (grant_sel == SEL_D) begin
            m_addr_next  = d_addr;
            m_wdata_next = d_wdata;
            m_wstrb_next = d_wstrb & STRB_WORD;
            last_d_next  = 1'b1;
            state_next   = BUSY_D;
         end else begin
            m_addr_next  = i_addr;
            m_wdata_next = 32'd0;
            m_wstrb_next = STRB_NONE;
            last_d_next  = 1'b0;
            state_next   = BUSY_I;
         end
      end
   end

   assign m_valid = m_valid_reg;
   assign m_addr  = m_addr_reg;
   assign m_wdata = m_wdata_reg;
   assign m_wstrb = m_wstrb_reg;
   assign i_ready = i_ready_reg;
   assign d_ready = d_ready_reg;
   assign i_rdata = i_rdata_reg;
   assign d_rdata = d_rdata_reg;

endmodule

// File: tb/tb_vigna_mem_arbiter.sv
// Directed bench for vigna_mem_arbiter. Instance A uses round-robin, instance
// B fixed data priority; both share the same master and slave stimulus.
module tb_vigna_mem_arbiter;

   logic        clk;
   logic        resetn;
   logic        i_valid;
   logic [31:0] i_addr;
   logic        d_valid;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        m_ready;
   logic [31:0] m_rdata;

   logic        a_i_ready, a_d_ready, a_m_valid;
   logic [31:0] a_i_rdata, a_d_rdata, a_m_addr, a_m_wdata;
   logic [3:0]  a_m_wstrb;
   logic        b_i_ready, b_d_ready, b_m_valid;
   logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata;
   logic [3:0]  b_m_wstrb;

   int n_cmp = 0;
   int n_err = 0;

   vigna_mem_arbiter #(.RR(1'b1)) dut_a (
      .clk(clk), .resetn(resetn),
      .i_valid(i_valid), .i_ready(a_i_ready), .i_addr(i_addr), .i_rdata(a_i_rdata),
      .d_valid(d_valid), .d_ready(a_d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(a_d_rdata),
      .m_valid(a_m_valid), .m_ready(m_ready), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
      .m_wstrb(a_m_wstrb), .m_rdata(m_rdata)
   );

   vigna_mem_arbiter #(.RR(1'b0)) dut_b (
      .clk(clk), .resetn(resetn),
      .i_valid(i_valid), .i_ready(b_i_ready), .i_addr(i_addr), .i_rdata(b_i_rdata),
      .d_valid(d_valid), .d_ready(b_d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_rdata(b_d_rdata),
      .m_valid(b_m_valid), .m_ready(m_ready), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
      .m_wstrb(b_m_wstrb), .m_rdata(m_rdata)
   );

   // 10 time-unit clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clk     = 1'b0;
      resetn  = 1'b1;
      i_valid = 1'b0;
      i_addr  = 32'd0;
      d_valid = 1'b0;
      d_addr  = 32'd0;
      d_wdata = 32'd0;
      d_wstrb = 4'd0;
      m_ready = 1'b0;
      m_rdata = 32'd0;

      // Reset values
      #2 resetn = 1'b0;
      #2;
      check("rst_m_valid", 32'(a_m_valid), 32'd0);
      check("rst_m_addr",  a_m_addr,       32'd0);
      check("rst_m_wstrb", 32'(a_m_wstrb), 32'd0);
      check("rst_i_ready", 32'(a_i_ready), 32'd0);
      check("rst_d_ready", 32'(a_d_ready), 32'd0);
      check("rst_i_rdata", a_i_rdata,      32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;

      // Contention from reset: D first, then I via cross-grant, alternating
      $display("txn: contention from reset, both ports valid");
      i_valid = 1'b1; i_addr = 32'h0000_1000;
      d_valid = 1'b1; d_addr = 32'h0000_2000; d_wstrb = 4'd0; d_wdata = 32'd0;
      m_ready = 1'b1; m_rdata = 32'h0000_00A1;
      step();
      check("cont_a_grant_d", a_m_addr, 32'h0000_2000);
      check("cont_b_grant_d", b_m_addr, 32'h0000_2000);
      check("cont_m_valid0",  32'(a_m_valid), 32'd1);
      step();
      check("cont_d_ready",   32'(a_d_ready), 32'd1);
      check("cont_i_ready0",  32'(a_i_ready), 32'd0);
      check("cont_d_rdata",   a_d_rdata, 32'h0000_00A1);
      m_rdata = 32'h0000_00B2;
      step();
      check("cont_a_xgrant_i", a_m_addr, 32'h0000_1000);
      check("cont_m_valid1",   32'(a_m_valid), 32'd1);
      check("cont_d_ready_off", 32'(a_d_ready), 32'd0);
      step();
      check("cont_i_ready",   32'(a_i_ready), 32'd1);
      check("cont_i_rdata",   a_i_rdata, 32'h0000_00B2);
      step();
      check("cont_a_xgrant_d", a_m_addr, 32'h0000_2000);
      check("cont_b_xgrant_d", b_m_addr, 32'h0000_2000);
      i_valid = 1'b0; d_valid = 1'b0;
      step();
      check("cont_d_ready2",  32'(a_d_ready), 32'd1);
      step();
      check("cont_idle_mv",   32'(a_m_valid), 32'd0);

      // Both valid in IDLE after a data grant: RR picks I, fixed priority D
      $display("txn: contention after data grant, RR vs fixed priority");
      i_valid = 1'b1; d_valid = 1'b1; m_rdata = 32'h0000_00C3;
      step();
      check("rr_a_grant_i",   a_m_addr, 32'h0000_1000);
      check("rr_b_grant_d",   b_m_addr, 32'h0000_2000);
      i_valid = 1'b0; d_valid = 1'b0;
      step();
      check("rr_a_i_ready",   32'(a_i_ready), 32'd1);
      check("rr_a_d_ready",   32'(a_d_ready), 32'd0);
      check("rr_b_d_ready",   32'(b_d_ready), 32'd1);
      check("rr_b_i_ready",   32'(b_i_ready), 32'd0);
      check("rr_b_d_rdata",   b_d_rdata, 32'h0000_00C3);
      step();
      check("rr_a_idle",      32'(a_m_valid), 32'd0);
      check("rr_b_idle",      32'(b_m_valid), 32'd0);

      // Single fetch, zero-wait slave
      $display("txn: single fetch addr 0x100");
      i_valid = 1'b1; i_addr = 32'h0000_0100; m_rdata = 32'h0000_0013;
      step();
      check("fetch_m_valid",  32'(a_m_valid), 32'd1);
      check("fetch_m_addr",   a_m_addr, 32'h0000_0100);
      check("fetch_m_wstrb",  32'(a_m_wstrb), 32'd0);
      step();
      check("fetch_i_ready",  32'(a_i_ready), 32'd1);
      check("fetch_i_rdata",  a_i_rdata, 32'h0000_0013);
      check("fetch_b_i_rdata", b_i_rdata, 32'h0000_0013);
      m_rdata = 32'hFFFF_FFFF;
      step();
      check("fetch_no_resample", 32'(a_m_valid), 32'd0);
      check("fetch_i_ready_off", 32'(a_i_ready), 32'd0);
      i_valid = 1'b0;
      step();
      check("fetch_rdata_held", a_i_rdata, 32'h0000_0013);

      // Store with a slow slave; master drops valid mid-transaction
      $display("txn: store 0xDEADBEEF to 0x20000004, slow slave");
      m_ready = 1'b0;
      d_valid = 1'b1; d_addr = 32'h2000_0004; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
      m_rdata = 32'hCAFE_0000;
      step();
      check("st_m_addr",      a_m_addr, 32'h2000_0004);
      check("st_m_wdata",     a_m_wdata, 32'hDEAD_BEEF);
      check("st_m_wstrb",     32'(a_m_wstrb), 32'd3);
      check("st_b_m_wdata",   b_m_wdata, 32'hDEAD_BEEF);
      check("st_b_m_wstrb",   32'(b_m_wstrb), 32'd3);
      step();
      check("st_hold1_mv",    32'(a_m_valid), 32'd1);
      check("st_hold1_rdy",   32'(a_d_ready), 32'd0);
      d_valid = 1'b0;
      step();
      check("st_hold2_mv",    32'(a_m_valid), 32'd1);
      check("st_hold2_addr",  a_m_addr, 32'h2000_0004);
      step();
      check("st_hold3_mv",    32'(a_m_valid), 32'd1);
      check("st_hold3_wstrb", 32'(a_m_wstrb), 32'd3);
      m_ready = 1'b1;
      step();
      check("st_d_ready",     32'(a_d_ready), 32'd1);
      check("st_d_rdata",     a_d_rdata, 32'hCAFE_0000);
      check("st_mv_off",      32'(a_m_valid), 32'd0);
      check("st_wstrb_off",   32'(a_m_wstrb), 32'd0);
      step();
      check("st_d_ready_off", 32'(a_d_ready), 32'd0);
      check("st_no_reissue",  32'(a_m_valid), 32'd0);
      step();
      check("st_idle_mv",     32'(a_m_valid), 32'd0);
      check("st_idle_rdy",    32'(a_d_ready), 32'd0);

      // Reset mid-transaction clears outputs without a clock edge
      $display("txn: data request aborted by reset");
      m_ready = 1'b0;
      d_valid = 1'b1; d_addr = 32'h0000_0040; d_wdata = 32'h0000_0077; d_wstrb = 4'b1100;
      step();
      check("abort_busy_mv",  32'(a_m_valid), 32'd1);
      check("abort_busy_strb", 32'(a_m_wstrb), 32'hC);
      #2 resetn = 1'b0;
      #1;
      check("abort_mv",       32'(a_m_valid), 32'd0);
      check("abort_wstrb",    32'(a_m_wstrb), 32'd0);
      check("abort_d_ready",  32'(a_d_ready), 32'd0);
      check("abort_m_addr",   a_m_addr, 32'd0);
      check("abort_d_rdata",  a_d_rdata, 32'd0);
      d_valid = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      $display("txn: fetch 0x300 after reset release");
      i_valid = 1'b1; i_addr = 32'h0000_0300; m_ready = 1'b1; m_rdata = 32'h0000_0055;
      step();
      check("post_m_addr",    a_m_addr, 32'h0000_0300);
      check("post_m_valid",   32'(a_m_valid), 32'd1);
      step();
      check("post_i_ready",   32'(a_i_ready), 32'd1);
      check("post_i_rdata",   a_i_rdata, 32'h0000_0055);
      check("post_d_ready",   32'(a_d_ready), 32'd0);
      i_valid = 1'b0;
      step();
      check("post_idle_mv",   32'(a_m_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vigna_mem_arbiter.md
# vigna_mem_arbiter

Two-master to one-slave memory arbiter that sits directly below the vigna core. It merges the core's instruction-fetch port (`i_*`) and load/store port (`d_*`) onto a single shared memory bus (`m_*`) for single-ported RAM or a unified system bus. Each transaction is fully serialised, with registered request and response paths. Arbitration is round-robin on contention, and each response is returned to the requesting port as a one-cycle ready pulse.

## Interface
Parameters:
- `RR`, default 1: 1 = round-robin on simultaneous requests; 0 = fixed priority, data port always wins.

Ports (clock and reset are named as in the rest of the codebase; reset is asynchronous and active-low):
- `clk` in 1: single clock; all logic is rising-edge.
- `resetn` in 1: asynchronous, active-low reset.
- `i_valid` in 1: instruction read request.
- `i_ready` out 1: one-cycle completion pulse for the instruction port.
- `i_addr` in 32: instruction address.
- `i_rdata` out 32: fetched word; holds its value until the next instruction completion.
- `d_valid` in 1: data request.
- `d_ready` out 1: one-cycle completion pulse for the data port.
- `d_addr` in 32: data address.
- `d_wdata` in 32: store data.
- `d_wstrb` in 4: byte strobes; 0 = read.
- `d_rdata` out 32: load word; holds its value until the next data completion.
- `m_valid` out 1: slave request.
- `m_ready` in 1: slave completion.
- `m_addr` out 32: slave address.
- `m_wdata` out 32: slave write data.
- `m_wstrb` out 4: slave byte strobes.
- `m_rdata` in 32: slave read data.

## Operation
- States:
  - IDLE: no transaction outstanding.
  - BUSY_I: instruction transaction on the slave bus.
  - BUSY_D: data transaction on the slave bus.
  - RESP: ready pulse being driven to the requesting port.
- Reset values: state = IDLE, `last_d` = 0. All outputs are 0: `i_ready`, `d_ready`, `m_valid`, `m_addr`, `m_wdata`, `m_wstrb`, `i_rdata`, `d_rdata`.
- IDLE, arbitration:
  - Only `i_valid` high: grant I.
  - Only `d_valid` high: grant D.
  - Both high with `RR`=1: grant D if `last_d`=0, else grant I.
  - Both high with `RR`=0: grant D.
- On grant I, register:
  - `m_addr` <= `i_addr`, `m_wstrb` <= 0, `m_wdata` <= 0, `m_valid` <= 1.
  - Next state BUSY_I; `last_d` <= 0.
- On grant D, register:
  - `m_addr` <= `d_addr`, `m_wdata` <= `d_wdata`, `m_wstrb` <= `d_wstrb`, `m_valid` <= 1.
  - Next state BUSY_D; `last_d` <= 1.
- BUSY_x: hold `m_*` stable until `m_ready`=1. On that edge:
  - `m_valid` <= 0, `m_wstrb` <= 0.
  - `x_rdata` <= `m_rdata`. The data port captures for writes too.
  - `x_ready` <= 1; next state RESP.
- RESP:
  - `x_ready` <= 0.
  - If the other port's valid is high, grant it directly, using the same register loads as IDLE. Otherwise go to IDLE.
  - The just-served port is never re-sampled in RESP. Its valid is still high in this cycle because the master drops it one edge after seeing ready.
- A master valid dropping during BUSY_x or RESP does not abort the transaction; the ready pulse is still issued.
- `m_ready` is ignored in IDLE and RESP.
- Never assert `i_ready` and `d_ready` in the same cycle. Never assert `m_valid` during RESP unless a cross-grant is being issued.

## Timing
- Zero-wait slave (`m_ready` high in the first `m_valid` cycle):
  - Request sampled at edge E0; `m_valid` high in cycle E0–E1.
  - `x_ready` high in cycle E1–E2.
  - Request-to-ready latency: 2 cycles.
- Slave asserting `m_ready` N cycles after `m_valid`: latency is N+2.
- Throughput, same port back-to-back: one transaction per 3 cycles (BUSY, RESP, IDLE).
- Throughput, alternating I/D with both pending: one transaction per 2 cycles, via the RESP cross-grant.
- `x_rdata` is valid from the `x_ready` cycle onward and stable until that port's next completion.
- Reset asserted mid-transaction: all outputs clear immediately (asynchronously), and the abandoned slave transaction is not completed. After reset release, arbitration restarts from IDLE on the first edge.

## Structure
- Shared package `vigna_bus_pkg`:
  - State encodings: IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2, RESP=2'd3.
  - Port-select constant `SEL_I`/`SEL_D`.
  - Strobe constants `STRB_NONE`=4'b0000 and `STRB_WORD`=4'b1111.
- Single module; no sub-module. The grant decision is a small combinational function of `i_valid`, `d_valid`, `last_d` and `RR`.

## Test plan
- Single fetch, zero-wait slave: `i_valid`=1, `i_addr`=0x0000_0100, `m_rdata`=0x0000_0013 -> `m_addr`=0x100 and `m_wstrb`=0 one cycle later; `i_ready` pulses 2 cycles after the request; `i_rdata`=0x13 held afterwards.
- Store with 3-cycle slave: `d_addr`=0x2000_0004, `d_wdata`=0xDEAD_BEEF, `d_wstrb`=4'b0011 -> `m_*` held for exactly 3 cycles; `d_ready` pulses 5 cycles after the request; `m_wstrb` returns to 0.
- Simultaneous requests, `RR`=1, from reset: D granted first, then I via RESP cross-grant with no IDLE cycle. Repeat with both pending -> grants alternate D, I, D, I.
- `RR`=0, both ports continuously valid: D always wins in IDLE; I served only via RESP cross-grant after each D.
- `resetn` dropped during BUSY_D with `m_valid`=1 -> `m_valid`, `d_ready` and `m_wstrb` go to 0 without a clock edge. After release, a new I request completes normally.
- Master drops `d_valid` during BUSY_D -> transaction completes and `d_ready` still pulses once; no second slave request is issued.
